// File: rtl/multiword_cla_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : multiword_cla_sequencer_if
// Brief  : Start/busy/done handshake and operand/result bus of the sequencer.
//          Optional MULTIWORD_CLA_SEQUENCER_SUB_EN adds the 'sub' request bit.
// Rev    : 1.0 - initial release
// ============================================================================
interface multiword_cla_sequencer_if #(
    parameter int N     = 4,
    parameter int WORDS = 4
);
    localparam int c_w = N * WORDS;

    logic           start;
    logic [c_w-1:0] A;
    logic [c_w-1:0] B;
    logic           C_in;
`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
    logic           sub;
`endif
    logic           busy;
    logic           done;
    logic [c_w-1:0] S;
    logic           C_out;

`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
    modport master (output start, A, B, C_in, sub, input busy, done, S, C_out);
    modport slave  (input start, A, B, C_in, sub, output busy, done, S, C_out);
`else
    modport master (output start, A, B, C_in, input busy, done, S, C_out);
    modport slave  (input start, A, B, C_in, output busy, done, S, C_out);
`endif

endinterface
`default_nettype wire

// File: rtl/multiword_cla_sequencer.sv
`default_nettype none
// ============================================================================
// Module : multiword_cla_sequencer
// Brief  : Wide add (optionally subtract, MULTIWORD_CLA_SEQUENCER_SUB_EN) done
//          as WORDS passes through one N-bit carry-look-ahead slice.
// Rev    : 1.0 - initial release
// ============================================================================
module multiword_cla_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multiword_cla_sequencer_if.slave bus
);
    localparam int c_w     = N * WORDS;
    localparam int c_res_w = c_w - N;
    localparam int c_idx_w = (WORDS > 1) ? (($clog2(WORDS) > 1) ? $clog2(WORDS) : 1) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_busy;
    logic                 w_done;

    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_res_w-1:0]   r_res;
    logic [c_w-1:0]       r_s;
    logic                 r_cout;

    logic                 w_accept;
    logic                 w_last;
    logic [c_w-1:0]       w_b_load;
    logic                 w_c_load;
    logic [N-1:0]         w_a_chunk;
    logic [N-1:0]         w_b_chunk;
    logic [N-1:0]         w_g;
    logic [N-1:0]         w_p;
    logic [N:0]           w_c;
    logic [N-1:0]         w_sum;
    logic                 w_prop;

    assign w_accept = bus.start && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_idx == c_last);

    // Subtraction is A + ~B + 1, so only the latched B and seed carry differ
`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
    assign w_b_load = bus.sub ? ~bus.B : bus.B;
    assign w_c_load = bus.sub ? 1'b1   : bus.C_in;
`else
    assign w_b_load = bus.B;
    assign w_c_load = bus.C_in;
`endif

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_a_chunk = r_a[k*N +: N];
                w_b_chunk = r_b[k*N +: N];
            end
        end
    end

    assign w_g = w_a_chunk & w_b_chunk;
    assign w_p = w_a_chunk | w_b_chunk;

    // Each carry is the flattened sum-of-products of the G/P recurrence
    always_comb begin
        w_c    = '0;
        w_prop = 1'b0;
        w_c[0] = r_carry;
        for (int i = 0; i < N; i++) begin
            w_c[i+1] = w_g[i];
            w_prop   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_g[j] & w_prop);
                w_prop   = w_prop & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_prop & r_carry);
        end
    end

    assign w_sum = w_a_chunk ^ w_b_chunk ^ w_c[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? ST_RUN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_c[N];
            for (int k = 0; k < WORDS - 1; k++) begin
                if (r_idx == c_idx_w'(k)) r_res[k*N +: N] <= w_sum;
            end
            // Top chunk goes straight to S so partial sums never appear there
            if (w_last) begin
                r_s    <= {w_sum, r_res};
                r_cout <= w_c[N];
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.S     = r_s;
    assign bus.C_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_multiword_cla_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_multiword_cla_sequencer
// Brief  : Directed self-checking bench for multiword_cla_sequencer (N=4, WORDS=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_multiword_cla_sequencer;
    localparam int N     = 4;
    localparam int WORDS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    multiword_cla_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

    multiword_cla_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.C_in  = cin;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called on the first negedge after the accepting edge (n=1)
    task automatic wait_done(input logic [15:0] s_ref, output int n,
                             output int busy_cnt, output bit s_moved);
        n        = 1;
        busy_cnt = 0;
        s_moved  = 1'b0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.S !== s_ref) s_moved = 1'b1;
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passed++;
        checks++; if (bus.S !== 16'h0000) $display("FAIL reset_S: got %h expected 0000", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL reset_C_out: got %b expected 0", bus.C_out); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_wrap_add();
        int n, b; bit m;
        drive_start(16'hFFFF, 16'h0001, 1'b0);
        wait_done(16'h0000, n, b, m);
        checks++; if (n !== 5) $display("FAIL wrap_latency: got %0d expected 5", n); else passed++;
        checks++; if (b !== 4) $display("FAIL wrap_busy_cycles: got %0d expected 4", b); else passed++;
        checks++; if (bus.S !== 16'h0000) $display("FAIL wrap_S: got %h expected 0000", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b1) $display("FAIL wrap_C_out: got %b expected 1", bus.C_out); else passed++;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL wrap_done_pulse: got %b expected 0", bus.done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL wrap_idle_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_hold_and_cin();
        int n, b; bit m;
        drive_start(16'h1234, 16'h4321, 1'b1);
        bus.A    = 16'hFFFF;
        bus.B    = 16'hFFFF;
        bus.C_in = 1'b0;
        wait_done(16'h0000, n, b, m);
        checks++; if (m !== 1'b0) $display("FAIL hold_S_before_done: got moved=%b expected 0", m); else passed++;
        checks++; if (n !== 5) $display("FAIL hold_latency: got %0d expected 5", n); else passed++;
        checks++; if (bus.S !== 16'h5556) $display("FAIL hold_S: got %h expected 5556", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL hold_C_out: got %b expected 0", bus.C_out); else passed++;
    endtask

    task automatic test_back_to_back();
        int n, b, gap; bit m;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h1111;
        bus.B     = 16'h2222;
        bus.C_in  = 1'b0;
        @(negedge clk);
        bus.A     = 16'h8000;
        bus.B     = 16'h8000;
        wait_done(16'h5556, n, b, m);
        checks++; if (n !== 5) $display("FAIL b2b_first_latency: got %0d expected 5", n); else passed++;
        checks++; if (bus.S !== 16'h3333) $display("FAIL b2b_first_S: got %h expected 3333", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL b2b_first_C_out: got %b expected 0", bus.C_out); else passed++;
        @(negedge clk);
        bus.start = 1'b0;
        gap = 1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_rerun_busy: got %b expected 1", bus.busy); else passed++;
        while (bus.done !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checks++; if (gap !== 5) $display("FAIL b2b_gap: got %0d expected 5", gap); else passed++;
        checks++; if (bus.S !== 16'h0000) $display("FAIL b2b_second_S: got %h expected 0000", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b1) $display("FAIL b2b_second_C_out: got %b expected 1", bus.C_out); else passed++;
    endtask

    task automatic test_ignore_start_in_run();
        int k, extra;
        drive_start(16'h00F0, 16'h0010, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'hAAAA;
        bus.B     = 16'h5555;
        @(negedge clk);
        bus.start = 1'b0;
        k = 3;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k !== 5) $display("FAIL ignore_latency: got %0d expected 5", k); else passed++;
        checks++; if (bus.S !== 16'h0100) $display("FAIL ignore_S: got %h expected 0100", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL ignore_C_out: got %b expected 0", bus.C_out); else passed++;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) $display("FAIL ignore_extra_done: got %0d expected 0", extra); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int n, b; bit m;
        drive_start(16'h5555, 16'h5555, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus.done); else passed++;
        checks++; if (bus.S !== 16'h0000) $display("FAIL midrst_S: got %h expected 0000", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL midrst_C_out: got %b expected 0", bus.C_out); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL midrst_no_done: got %b expected 0", bus.done); else passed++;
        drive_start(16'h00FF, 16'h0001, 1'b0);
        wait_done(16'h0000, n, b, m);
        checks++; if (n !== 5) $display("FAIL midrst_latency: got %0d expected 5", n); else passed++;
        checks++; if (bus.S !== 16'h0100) $display("FAIL midrst_S_after: got %h expected 0100", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL midrst_C_out_after: got %b expected 0", bus.C_out); else passed++;
    endtask

    task automatic test_carry_chain();
        int n, b; bit m;
        drive_start(16'h7FFF, 16'h0000, 1'b1);
        wait_done(16'h0100, n, b, m);
        checks++; if (bus.S !== 16'h8000) $display("FAIL chain1_S: got %h expected 8000", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL chain1_C_out: got %b expected 0", bus.C_out); else passed++;
        drive_start(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(16'h8000, n, b, m);
        checks++; if (n !== 5) $display("FAIL chain2_latency: got %0d expected 5", n); else passed++;
        checks++; if (bus.S !== 16'hFFFF) $display("FAIL chain2_S: got %h expected FFFF", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b1) $display("FAIL chain2_C_out: got %b expected 1", bus.C_out); else passed++;
    endtask

`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
    task automatic test_sub();
        int n, b; bit m;
        bus.sub = 1'b1;
        drive_start(16'h0005, 16'h0007, 1'b0);
        wait_done(16'hFFFF, n, b, m);
        checks++; if (bus.S !== 16'hFFFE) $display("FAIL sub1_S: got %h expected FFFE", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b0) $display("FAIL sub1_C_out: got %b expected 0", bus.C_out); else passed++;
        drive_start(16'h0007, 16'h0005, 1'b0);
        wait_done(16'hFFFE, n, b, m);
        checks++; if (bus.S !== 16'h0002) $display("FAIL sub2_S: got %h expected 0002", bus.S); else passed++;
        checks++; if (bus.C_out !== 1'b1) $display("FAIL sub2_C_out: got %b expected 1", bus.C_out); else passed++;
        bus.sub = 1'b0;
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C_in  = 1'b0;
`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
        bus.sub   = 1'b0;
`endif
        test_reset();
        test_wrap_add();
        test_hold_and_cin();
        test_back_to_back();
        test_ignore_start_in_run();
        test_reset_mid_run();
        test_carry_chain();
`ifdef MULTIWORD_CLA_SEQUENCER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
